operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/core_pkg.sv | 28 ++
 rtl/fwd_mux.sv | 40 ++++
 rtl/operand_fetch.sv | 151 +++++++++++++++
 tb/tb_operand_fetch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: architectural widths, the operand-fetch output
// payload layout and a small register-index match helper.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Everything the execute stage receives except the opaque control bundle,
  // whose width is a per-instance parameter and so cannot live in here.
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } of_payload_t;

  localparam int PAYLOAD_W = $bits(of_payload_t);

  // True when a producer destination names a real (non-x0) source register.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs);
    return (rd != {REG_ADDR_W{1'b0}}) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand selection for one source register: x0, EX bypass, MEM bypass or
// register-file data. WB is never bypassed because the register file writes
// on the falling edge, so its data is already on i_rf_data.
module fwd_mux
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_reg_write,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [XLEN-1:0]       i_ex_result,
  input  logic                  i_mem_valid,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [XLEN-1:0]       i_mem_result,
  output logic [XLEN-1:0]       o_operand
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_ex_valid  & i_ex_reg_write  & (i_ex_rd  == i_rs);
  assign w_mem_hit = i_mem_valid & i_mem_reg_write & (i_mem_rd == i_rs);

  // Priority select: x0 reads zero, then the youngest producer wins.
  always_comb begin
    o_operand = i_rf_data;
    if (i_rs == {REG_ADDR_W{1'b0}}) begin
      o_operand = {XLEN{1'b0}};
    end else if (w_ex_hit) begin
      o_operand = i_ex_result;
    end else if (w_mem_hit) begin
      o_operand = i_mem_result;
    end else begin
      o_operand = i_rf_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch pipeline register: reads the register file, bypasses EX/MEM
// results, detects load-use hazards and hands a registered payload to EX.
module operand_fetch
  import core_pkg::*;
#(
  parameter int CTRL_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_is_load,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic [REG_ADDR_W-1:0] rf_addr_1,
  output logic [REG_ADDR_W-1:0] rf_addr_2,
  input  logic [XLEN-1:0]       rf_data_1,
  input  logic [XLEN-1:0]       rf_data_2,
  input  logic                  fwd_ex_valid,
  input  logic                  fwd_ex_reg_write,
  input  logic                  fwd_ex_is_load,
  input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]       fwd_ex_result,
  input  logic                  fwd_mem_valid,
  input  logic                  fwd_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]       fwd_mem_result,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_imm,
  output logic [XLEN-1:0]       out_rs1_val,
  output logic [XLEN-1:0]       out_rs2_val,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_is_load,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [15:0]           stall_cnt
);

  logic              r_valid;
  of_payload_t       r_payload;
  logic [CTRL_W-1:0] r_ctrl;
  logic [15:0]       r_stall_cnt;

  logic              w_space;
  logic              w_hazard;
  logic              w_accept;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;
  of_payload_t       w_next;

  assign rf_addr_1 = in_rs1;
  assign rf_addr_2 = in_rs2;

  fwd_mux u_fwd_rs1 (
    .i_rs            (in_rs1),
    .i_rf_data       (rf_data_1),
    .i_ex_valid      (fwd_ex_valid),
    .i_ex_reg_write  (fwd_ex_reg_write),
    .i_ex_rd         (fwd_ex_rd),
    .i_ex_result     (fwd_ex_result),
    .i_mem_valid     (fwd_mem_valid),
    .i_mem_reg_write (fwd_mem_reg_write),
    .i_mem_rd        (fwd_mem_rd),
    .i_mem_result    (fwd_mem_result),
    .o_operand       (w_rs1_val)
  );

  fwd_mux u_fwd_rs2 (
    .i_rs            (in_rs2),
    .i_rf_data       (rf_data_2),
    .i_ex_valid      (fwd_ex_valid),
    .i_ex_reg_write  (fwd_ex_reg_write),
    .i_ex_rd         (fwd_ex_rd),
    .i_ex_result     (fwd_ex_result),
    .i_mem_valid     (fwd_mem_valid),
    .i_mem_reg_write (fwd_mem_reg_write),
    .i_mem_rd        (fwd_mem_rd),
    .i_mem_result    (fwd_mem_result),
    .o_operand       (w_rs2_val)
  );

  // A load still in EX cannot be bypassed; either source naming it must wait.
  assign w_hazard = in_valid & fwd_ex_valid & fwd_ex_is_load &
                    (reg_match(fwd_ex_rd, in_rs1) | reg_match(fwd_ex_rd, in_rs2));
  assign w_space  = ~r_valid | out_ready;
  assign w_accept = in_valid & w_space & ~w_hazard & ~flush;
  assign in_ready = flush ? 1'b1 : (w_space & ~w_hazard);

  // Assemble the payload that would be captured this cycle.
  always_comb begin
    w_next           = r_payload;
    w_next.pc        = in_pc;
    w_next.imm       = in_imm;
    w_next.rs1_val   = w_rs1_val;
    w_next.rs2_val   = w_rs2_val;
    w_next.rd        = in_rd;
    w_next.reg_write = in_reg_write;
    w_next.is_load   = in_is_load;
  end

  // Output register: flush squashes, accept loads, drain/bubble clears valid,
  // otherwise hold for a stalled consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_payload <= {PAYLOAD_W{1'b0}};
      r_ctrl    <= {CTRL_W{1'b0}};
    end else if (flush) begin
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_payload <= w_next;
      r_ctrl    <= in_ctrl;
    end else if (w_space) begin
      r_valid   <= 1'b0;
    end else begin
      r_valid   <= r_valid;
    end
  end

  // Saturating count of load-use stall cycles; a flush cycle is not a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_hazard & ~flush & (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_payload.pc;
  assign out_imm       = r_payload.imm;
  assign out_rs1_val   = r_payload.rs1_val;
  assign out_rs2_val   = r_payload.rs2_val;
  assign out_rd        = r_payload.rd;
  assign out_reg_write = r_payload.reg_write;
  assign out_is_load   = r_payload.is_load;
  assign out_ctrl      = r_ctrl;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: behavioural reference model, a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_operand_fetch;

  localparam int CTRL_W = 16;

  logic              clk;
  logic              reset;
  logic              in_valid, in_ready;
  logic [31:0]       in_pc, in_imm;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_reg_write, in_is_load;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        rf_addr_1, rf_addr_2;
  logic [31:0]       rf_data_1, rf_data_2;
  logic              fwd_ex_valid, fwd_ex_reg_write, fwd_ex_is_load;
  logic [4:0]        fwd_ex_rd;
  logic [31:0]       fwd_ex_result;
  logic              fwd_mem_valid, fwd_mem_reg_write;
  logic [4:0]        fwd_mem_rd;
  logic [31:0]       fwd_mem_result;
  logic              flush;
  logic              out_valid, out_ready;
  logic [31:0]       out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [4:0]        out_rd;
  logic              out_reg_write, out_is_load;
  logic [CTRL_W-1:0] out_ctrl;
  logic [15:0]       stall_cnt;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_err    = 0;

  operand_fetch #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
    .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_reg_write(fwd_ex_reg_write),
    .fwd_ex_is_load(fwd_ex_is_load), .fwd_ex_rd(fwd_ex_rd),
    .fwd_ex_result(fwd_ex_result),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_reg_write(fwd_mem_reg_write),
    .fwd_mem_rd(fwd_mem_rd), .fwd_mem_result(fwd_mem_result),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_load(out_is_load),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  // Register file stand-in: combinational read of a fixed image.
  assign rf_data_1 = rf[rf_addr_1];
  assign rf_data_2 = rf[rf_addr_2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic              m_valid;
  logic [31:0]       m_pc, m_imm, m_rs1, m_rs2;
  logic [4:0]        m_rd;
  logic              m_rw, m_ld;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_stall;

  function automatic logic [31:0] m_opnd(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (fwd_ex_valid && fwd_ex_reg_write && fwd_ex_rd == rs) return fwd_ex_result;
    if (fwd_mem_valid && fwd_mem_reg_write && fwd_mem_rd == rs) return fwd_mem_result;
    return rf[rs];
  endfunction

  function automatic logic m_hazard();
    return in_valid && fwd_ex_valid && fwd_ex_is_load && fwd_ex_rd != 5'd0 &&
           (fwd_ex_rd == in_rs1 || fwd_ex_rd == in_rs2);
  endfunction

  function automatic logic m_ready();
    if (flush) return 1'b1;
    return (!m_valid || out_ready) && !m_hazard();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0; m_pc <= 32'h0; m_imm <= 32'h0; m_rs1 <= 32'h0; m_rs2 <= 32'h0;
      m_rd <= 5'd0; m_rw <= 1'b0; m_ld <= 1'b0; m_ctrl <= '0; m_stall <= 0;
    end else begin
      if (m_hazard() && !flush && m_stall != 65535) m_stall <= m_stall + 1;
      if (flush) m_valid <= 1'b0;
      else if (in_valid && (!m_valid || out_ready) && !m_hazard()) begin
        m_valid <= 1'b1; m_pc <= in_pc; m_imm <= in_imm;
        m_rs1 <= m_opnd(in_rs1); m_rs2 <= m_opnd(in_rs2);
        m_rd <= in_rd; m_rw <= in_reg_write; m_ld <= in_is_load; m_ctrl <= in_ctrl;
      end else if (!m_valid || out_ready) m_valid <= 1'b0;
    end
  end

  // Compare process: every out-of-reset cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rf_addr_1", rf_addr_1, in_rs1);
      check("rf_addr_2", rf_addr_2, in_rs2);
      check("in_ready", in_ready, m_ready());
      check("out_valid", out_valid, m_valid);
      check("stall_cnt", stall_cnt, m_stall[15:0]);
      if (m_valid) begin
        check("out_pc", out_pc, m_pc);
        check("out_imm", out_imm, m_imm);
        check("out_rs1_val", out_rs1_val, m_rs1);
        check("out_rs2_val", out_rs2_val, m_rs2);
        check("out_rd", out_rd, m_rd);
        check("out_reg_write", out_reg_write, m_rw);
        check("out_is_load", out_is_load, m_ld);
        check("out_ctrl", out_ctrl, m_ctrl);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_fwd();
    fwd_ex_valid = 1'b0; fwd_ex_reg_write = 1'b0; fwd_ex_is_load = 1'b0;
    fwd_ex_rd = 5'd0; fwd_ex_result = 32'h0;
    fwd_mem_valid = 1'b0; fwd_mem_reg_write = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_result = 32'h0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd);
    in_valid = 1'b1; in_pc = pc; in_imm = pc ^ 32'h5A5A_0000;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_reg_write = 1'b1; in_is_load = 1'b0; in_ctrl = pc[15:0] ^ 16'h00FF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 | i;
    rf[0] = 32'hFFFF_FFFF;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_pc = 32'h0; in_imm = 32'h0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_reg_write = 1'b0; in_is_load = 1'b0; in_ctrl = '0;
    clear_fwd();
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_stall_cnt", stall_cnt, 16'h0);
    check("reset_out_pc", out_pc, 32'h0);
    tick(); tick();
    reset = 1'b1;

    // Back-to-back, no hazards.
    for (int i = 0; i < 4; i++) begin
      set_instr(32'h100 + 32'(4 * i), 5'(i + 1), 5'(i + 9), 5'(i + 20));
      tick();
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_pc", out_pc, 32'h100 + 32'(4 * i));
      check("b2b_rs1", out_rs1_val, 32'hC0DE_0001 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drain", out_valid, 1'b0);

    // EX beats MEM for the same register.
    set_instr(32'h180, 5'd5, 5'd3, 5'd6);
    fwd_ex_valid = 1'b1; fwd_ex_reg_write = 1'b1; fwd_ex_rd = 5'd5; fwd_ex_result = 32'hAAAA_0000;
    fwd_mem_valid = 1'b1; fwd_mem_reg_write = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_result = 32'h1111_2222;
    tick();
    check("ex_prio_rs1", out_rs1_val, 32'hAAAA_0000);
    check("ex_prio_rs2", out_rs2_val, 32'hC0DE_0003);
    fwd_ex_valid = 1'b0;
    set_instr(32'h184, 5'd5, 5'd3, 5'd6);
    tick();
    check("mem_fwd_rs1", out_rs1_val, 32'h1111_2222);
    clear_fwd();

    // Load-use bubble then MEM forward.
    set_instr(32'h190, 5'd1, 5'd7, 5'd8);
    fwd_ex_valid = 1'b1; fwd_ex_reg_write = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_rd = 5'd7;
    #1;
    check("lu_in_ready", in_ready, 1'b0);
    tick();
    check("lu_bubble", out_valid, 1'b0);
    check("lu_stall_cnt", stall_cnt, 16'd1);
    clear_fwd();
    fwd_mem_valid = 1'b1; fwd_mem_reg_write = 1'b1; fwd_mem_rd = 5'd7; fwd_mem_result = 32'h0000_1234;
    #1;
    check("lu_ready_again", in_ready, 1'b1);
    tick();
    check("lu_valid", out_valid, 1'b1);
    check("lu_rs2", out_rs2_val, 32'h0000_1234);
    check("lu_pc", out_pc, 32'h190);
    clear_fwd();

    // x0 never forwards and never stalls.
    set_instr(32'h1A0, 5'd0, 5'd2, 5'd9);
    fwd_ex_valid = 1'b1; fwd_ex_reg_write = 1'b1; fwd_ex_is_load = 1'b1;
    fwd_ex_rd = 5'd0; fwd_ex_result = 32'h0000_DEAD;
    #1;
    check("x0_in_ready", in_ready, 1'b1);
    tick();
    check("x0_rs1", out_rs1_val, 32'h0);
    check("x0_stall_cnt", stall_cnt, 16'd1);
    clear_fwd();

    // Hold under backpressure, then flush.
    set_instr(32'h200, 5'd1, 5'd2, 5'd3);
    tick();
    out_ready = 1'b0;
    set_instr(32'h300, 5'd4, 5'd5, 5'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_in_ready", in_ready, 1'b0);
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_pc", out_pc, 32'h200);
      check("hold_rs1", out_rs1_val, 32'hC0DE_0001);
    end
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b1);
    tick();
    check("flush_valid", out_valid, 1'b0);
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // Randomized traffic; small register range keeps matches frequent.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_pc = $urandom; in_imm = $urandom;
      in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_rd = 5'($urandom); in_reg_write = 1'($urandom); in_is_load = 1'($urandom);
      in_ctrl = CTRL_W'($urandom);
      fwd_ex_valid = 1'($urandom); fwd_ex_reg_write = 1'($urandom);
      fwd_ex_is_load = ($urandom_range(0, 2) == 0); fwd_ex_rd = 5'($urandom_range(0, 7));
      fwd_ex_result = $urandom;
      fwd_mem_valid = 1'($urandom); fwd_mem_reg_write = 1'($urandom);
      fwd_mem_rd = 5'($urandom_range(0, 7)); fwd_mem_result = $urandom;
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    // Asynchronous reset pulse mid-stream.
    flush = 1'b0; out_ready = 1'b1; clear_fwd();
    set_instr(32'h380, 5'd1, 5'd2, 5'd3);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_stall_cnt", stall_cnt, 16'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_rs1", out_rs1_val, 32'h0);
    #9;
    reset = 1'b1;
    set_instr(32'h400, 5'd10, 5'd11, 5'd12);
    tick();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_pc", out_pc, 32'h400);
    check("post_rst_rs2", out_rs2_val, 32'hC0DE_000B);

    // Sustained hazard to reach stall counter saturation.
    set_instr(32'h500, 5'd7, 5'd1, 5'd2);
    fwd_ex_valid = 1'b1; fwd_ex_reg_write = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_rd = 5'd7;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    check("sat_valid", out_valid, 1'b0);
    in_valid = 1'b0; clear_fwd();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
